// File: rtl/morse_pkg.sv
// morse_pkg: shared types and default timing constants for the Morse key
// timer slice.
//   state_e : control FSM states
//   sym_e   : symbol encoding reported on sym_is_dash (DOT=0, DASH=1)
//   *_DEF   : default tick thresholds, in 100 ms units
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    GAP,
    LGAP,
    ABORT
  } state_e;

  typedef enum logic {
    DOT  = 1'b0,
    DASH = 1'b1
  } sym_e;

  localparam int unsigned DASH_DEF       = 3;
  localparam int unsigned LETTER_GAP_DEF = 3;
  localparam int unsigned WORD_GAP_DEF   = 7;
  localparam int unsigned MAX_PRESS_DEF  = 12;

  // Symbols-per-letter counter helper: saturates at 7.
  function automatic logic [2:0] len_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/morse_key_sync.sv
// morse_key_sync: brings the raw key into the clk domain and reports
// registered single-cycle edge pulses.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   key_in : raw key, asynchronous to clk, 1 = pressed
//   rise   : one-cycle pulse, synchronized key went 0->1
//   fall   : one-cycle pulse, synchronized key went 1->0
module morse_key_sync (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic key_s_q, key_s_d;
  logic key_q, key_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d  = key_in;
    key_s_d = meta_q;
    key_d   = key_s_q;
    rise_d  = key_s_q & ~key_q;
    fall_d  = ~key_s_q & key_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b0;
      key_s_q <= 1'b0;
      key_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      key_s_q <= key_s_d;
      key_q   <= key_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/morse_key_timer.sv
// morse_key_timer: times Morse key presses/releases in tick_100ms units,
// classifies presses as dot/dash and flags letter and word gaps.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   enable      : active high; low forces IDLE on the next cycle
//   key_in      : raw key, asynchronous, 1 = pressed
//   tick_100ms  : one-cycle pulse from the 100 ms timer
//   sym_valid   : pulse, a symbol completed; sym_is_dash qualifies it
//   letter_end  : pulse, letter gap reached
//   word_end    : pulse, word gap reached
//   press_err   : pulse, press reached MAX_PRESS_TICKS (no symbol emitted)
//   busy        : high whenever the FSM is not in IDLE
//   letter_len  : (only with MORSE_LETTER_LEN_EN) symbols in current letter
// Optional feature macro: MORSE_LETTER_LEN_EN.
// Parameter constraints: WORD_GAP_TICKS > LETTER_GAP_TICKS,
// DASH_TICKS < MAX_PRESS_TICKS <= 2**CNT_W-1.
module morse_key_timer
  import morse_pkg::*;
#(
  parameter int unsigned CNT_W            = 4,
  parameter int unsigned DASH_TICKS       = DASH_DEF,
  parameter int unsigned LETTER_GAP_TICKS = LETTER_GAP_DEF,
  parameter int unsigned WORD_GAP_TICKS   = WORD_GAP_DEF,
  parameter int unsigned MAX_PRESS_TICKS  = MAX_PRESS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_in,
  input  logic       tick_100ms,
  output logic       sym_valid,
  output logic       sym_is_dash,
  output logic       letter_end,
  output logic       word_end,
  output logic       press_err,
  output logic       busy
`ifdef MORSE_LETTER_LEN_EN
  ,
  output logic [2:0] letter_len
`endif
);

  logic rise, fall;

  morse_key_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .rise   (rise),
    .fall   (fall)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               sym_valid_q, sym_valid_d;
  sym_e               sym_q, sym_d;
  logic               letter_end_q, letter_end_d;
  logic               word_end_q, word_end_d;
  logic               press_err_q, press_err_d;
  logic               busy_q, busy_d;

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Key edges are tested before ticks in every state, so an edge that
  // coincides with a tick consumes the cycle and the tick is dropped.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sym_valid_d  = 1'b0;
    sym_d        = DOT;
    letter_end_d = 1'b0;
    word_end_d   = 1'b0;
    press_err_d  = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESS;
            cnt_d   = '0;
          end
        end
        PRESS: begin
          if (fall) begin
            sym_valid_d = 1'b1;
            sym_d       = (cnt_q >= CNT_W'(DASH_TICKS)) ? DASH : DOT;
            state_d     = GAP;
            cnt_d       = '0;
          end else if (tick_100ms) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(MAX_PRESS_TICKS)) begin
              press_err_d = 1'b1;
              state_d     = ABORT;
            end
          end
        end
        ABORT: begin
          if (fall) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        GAP: begin
          if (rise) begin
            state_d = PRESS;
            cnt_d   = '0;
          end else if (tick_100ms) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(LETTER_GAP_TICKS)) begin
              letter_end_d = 1'b1;
              state_d      = LGAP;
            end
          end
        end
        LGAP: begin
          if (rise) begin
            state_d = PRESS;
            cnt_d   = '0;
          end else if (tick_100ms) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(WORD_GAP_TICKS)) begin
              word_end_d = 1'b1;
              state_d    = IDLE;
              cnt_d      = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sym_valid_q  <= 1'b0;
      sym_q        <= DOT;
      letter_end_q <= 1'b0;
      word_end_q   <= 1'b0;
      press_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sym_valid_q  <= sym_valid_d;
      sym_q        <= sym_d;
      letter_end_q <= letter_end_d;
      word_end_q   <= word_end_d;
      press_err_q  <= press_err_d;
      busy_q       <= busy_d;
    end
  end

  assign sym_valid   = sym_valid_q;
  assign sym_is_dash = sym_q;
  assign letter_end  = letter_end_q;
  assign word_end    = word_end_q;
  assign press_err   = press_err_q;
  assign busy        = busy_q;

`ifdef MORSE_LETTER_LEN_EN
  logic [2:0] letter_len_q, letter_len_d;

  // A rise out of LGAP starts a new letter; a rise out of GAP continues
  // the current one, so only the former clears the count.
  always_comb begin
    letter_len_d = letter_len_q;
    if (sym_valid_d) begin
      letter_len_d = len_inc(letter_len_q);
    end
    if (press_err_d || (state_d == IDLE) ||
        (state_q == LGAP && state_d == PRESS)) begin
      letter_len_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      letter_len_q <= '0;
    end else begin
      letter_len_q <= letter_len_d;
    end
  end

  assign letter_len = letter_len_q;
`endif

endmodule

// File: tb/tb_morse_key_timer.sv
module tb_morse_key_timer;

  logic clk        = 1'b0;
  logic rst        = 1'b0;
  logic enable     = 1'b0;
  logic key_in     = 1'b0;
  logic tick_100ms = 1'b0;
  logic sym_valid, sym_is_dash, letter_end, word_end, press_err, busy;
`ifdef MORSE_LETTER_LEN_EN
  logic [2:0] letter_len;
`endif

  morse_key_timer #(
    .CNT_W            (4),
    .DASH_TICKS       (3),
    .LETTER_GAP_TICKS (3),
    .WORD_GAP_TICKS   (7),
    .MAX_PRESS_TICKS  (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .key_in      (key_in),
    .tick_100ms  (tick_100ms),
    .sym_valid   (sym_valid),
    .sym_is_dash (sym_is_dash),
    .letter_end  (letter_end),
    .word_end    (word_end),
    .press_err   (press_err),
    .busy        (busy)
`ifdef MORSE_LETTER_LEN_EN
    ,
    .letter_len  (letter_len)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {EV_SYM, EV_LETTER, EV_WORD, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          dash;
    int          len;
    int unsigned at;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input int dash, input int len,
                         input int unsigned at);
    ev_t e;
    e.kind = k;
    e.dash = dash;
    e.len  = len;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Tick is high for one cycle; the FSM reacts on the following edge.
  task automatic tick();
    tick_100ms = 1'b1;
    @(negedge clk);
    tick_100ms = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic tick_ev(input ev_kind_e k, input int len);
    push_ev(k, 0, len, cyc + 1);
    tick();
  endtask

  // Key edge reaches the outputs four bench cycles after it is driven.
  task automatic press();
    key_in = 1'b1;
    wait_cyc(5);
  endtask

  task automatic release_sym(input int dash);
    push_ev(EV_SYM, dash, 0, cyc + 4);
    key_in = 1'b0;
    wait_cyc(5);
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    int       nh;
    ev_kind_e k;
    ev_t      e;
    if (rst && (sym_valid || letter_end || word_end || press_err)) begin
      nh = int'(sym_valid) + int'(letter_end) + int'(word_end) + int'(press_err);
      check("pulse_onehot", nh, 1);
      k = sym_valid ? EV_SYM : letter_end ? EV_LETTER : word_end ? EV_WORD : EV_ERR;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse",
                 int'(k), cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", int'(k), int'(e.kind));
        check("pulse_cycle", int'(cyc), int'(e.at));
        if (e.kind == EV_SYM) check("sym_is_dash", int'(sym_is_dash), e.dash);
`ifdef MORSE_LETTER_LEN_EN
        if (e.kind == EV_LETTER) check("letter_len", int'(letter_len), e.len);
`endif
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b0;
    enable = 1'b1;
    wait_cyc(3);
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_sym_is_dash", int'(sym_is_dash), 0);
    check("rst_letter_end", int'(letter_end), 0);
    check("rst_word_end", int'(word_end), 0);
    check("rst_press_err", int'(press_err), 0);
    check("rst_busy", int'(busy), 0);
`ifdef MORSE_LETTER_LEN_EN
    check("rst_letter_len", int'(letter_len), 0);
`endif
    rst = 1'b1;
    wait_cyc(2);

    // 1-tick press -> dot, then a 4-tick press in the same letter -> dash.
    press();
    check("busy_press", int'(busy), 1);
    tick();
    release_sym(0);
    check("busy_gap", int'(busy), 1);
    press();
    ticks(4);
    release_sym(1);
    ticks(2);
    tick_ev(EV_LETTER, 2);
    ticks(3);
    tick_ev(EV_WORD, 0);
    check("busy_after_word", int'(busy), 0);

    // Ticks in IDLE are ignored.
    ticks(8);

    // 0-tick dot, 2-tick gap, exact 3-tick dash; then a 2-tick dot as a new letter.
    press();
    release_sym(0);
    ticks(2);
    press();
    ticks(3);
    release_sym(1);
    ticks(2);
    tick_ev(EV_LETTER, 2);
    press();
    ticks(2);
    release_sym(0);
    ticks(2);
    tick_ev(EV_LETTER, 1);
    ticks(3);
    tick_ev(EV_WORD, 0);

    // Overlong press: error at the 12th tick, no symbol on release.
    press();
    ticks(11);
    tick_ev(EV_ERR, 0);
    ticks(2);
    check("busy_abort", int'(busy), 1);
    key_in = 1'b0;
    wait_cyc(6);
    check("busy_after_abort", int'(busy), 0);

    // Rise and tick in the same cycle while in GAP with cnt=2.
    press();
    tick();
    release_sym(0);
    ticks(2);
    key_in = 1'b1;
    wait_cyc(3);
    tick_100ms = 1'b1;
    @(negedge clk);
    tick_100ms = 1'b0;
    @(negedge clk);
    check("busy_collision", int'(busy), 1);
    ticks(2);
    release_sym(0);
    ticks(2);
    tick_ev(EV_LETTER, 2);
    ticks(3);
    tick_ev(EV_WORD, 0);

    // enable dropped mid-press.
    press();
    tick();
    enable = 1'b0;
    @(negedge clk);
    check("busy_enable_low", int'(busy), 0);
    key_in = 1'b0;
    wait_cyc(6);
    ticks(3);
    enable = 1'b1;
    wait_cyc(2);
    check("busy_enable_back", int'(busy), 0);

    // Key already held when enable rises is not a rise.
    enable = 1'b0;
    key_in = 1'b1;
    wait_cyc(6);
    enable = 1'b1;
    wait_cyc(6);
    check("busy_held_key", int'(busy), 0);
    key_in = 1'b0;
    wait_cyc(6);
    check("busy_held_release", int'(busy), 0);

    // Reset mid-press.
    press();
    tick();
    rst = 1'b0;
    #1;
    check("busy_rst_mid", int'(busy), 0);
    check("sym_valid_rst_mid", int'(sym_valid), 0);
    key_in = 1'b0;
    @(negedge clk);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(6);
    check("busy_after_rst", int'(busy), 0);

    // Normal operation resumes: 3-tick dash as a one-symbol letter.
    press();
    ticks(3);
    release_sym(1);
    ticks(2);
    tick_ev(EV_LETTER, 1);
    ticks(3);
    tick_ev(EV_WORD, 0);

    wait_cyc(10);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_key_timer.md
Name: morse_key_timer

Overview:
- Downstream consumer of the 100 ms timeout pulse produced by the Count-to-100 timer stage.
- Times the player's Morse key presses and releases in 100 ms units and classifies each press as a dot or a dash.
- Flags letter gaps and word gaps so that game control can compare the entered symbols against the ROM target.
- Single clock domain; all outputs are registered, single-cycle pulses.

Parameters:
- CNT_W, 4: width of the tick counter; the counter saturates at 2^CNT_W-1.
- DASH_TICKS, 3: a press lasting at least this many ticks is a dash; anything shorter is a dot.
- LETTER_GAP_TICKS, 3: release time, in ticks, that closes a letter.
- WORD_GAP_TICKS, 7: release time, in ticks, that closes a word. Must be greater than LETTER_GAP_TICKS.
- MAX_PRESS_TICKS, 12: a press reaching this many ticks is an error. Must be greater than DASH_TICKS and at most 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  active high; low forces IDLE synchronously
- key_in  in  1  raw Morse key, asynchronous to clk, 1 = pressed
- tick_100ms  in  1  one-cycle pulse from the 100 ms timer
- sym_valid  out  1  one-cycle pulse: a symbol has completed
- sym_is_dash  out  1  qualified by sym_valid; 1 = dash, 0 = dot
- letter_end  out  1  one-cycle pulse: letter gap reached
- word_end  out  1  one-cycle pulse: word gap reached
- press_err  out  1  one-cycle pulse: press reached MAX_PRESS_TICKS
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, synchronizer flops=0, all outputs 0.
- Key conditioning:
  - key_in passes through a 2-flop synchronizer to give key_s.
  - key_q is key_s delayed one cycle.
  - rise = key_s & ~key_q; fall = ~key_s & key_q.
- Latency: an edge on key_in, sampled at clk edge N, produces its output pulse after edge N+3.
- IDLE:
  - On rise: go to PRESS with cnt=0.
  - tick_100ms is ignored, so no gap is counted before the first press.
- PRESS:
  - Each tick increments cnt.
  - On fall: pulse sym_valid; sym_is_dash = (cnt >= DASH_TICKS); go to GAP with cnt=0.
  - A fall with cnt=0 yields a dot.
  - When cnt reaches MAX_PRESS_TICKS: pulse press_err and go to ABORT. No symbol is emitted.
- ABORT:
  - Wait for fall, then go to IDLE.
  - The symbols accepted so far in the letter are discarded by game control on press_err.
- GAP:
  - Each tick increments cnt.
  - On rise: go to PRESS with cnt=0 (same letter).
  - When cnt reaches LETTER_GAP_TICKS: pulse letter_end and go to LGAP. cnt keeps counting.
- LGAP:
  - Each tick increments cnt.
  - On rise: go to PRESS with cnt=0 (new letter).
  - When cnt reaches WORD_GAP_TICKS: pulse word_end, go to IDLE, cnt=0.
- Simultaneous key edge and tick in the same cycle: the edge wins and the tick is dropped.
- Counter: cnt saturates and never wraps.
- Output pulses: at most one of sym_valid, letter_end, word_end, press_err is high in any cycle.
- enable=0: next cycle state=IDLE, cnt=0, no pulses. The synchronizer keeps running, so a key already held when enable rises does not register a rise.
- Reset mid-press: no symbol is emitted and the block restarts in IDLE.

Optional Feature:
- Macro: MORSE_LETTER_LEN_EN.
- Defined:
  - Adds output letter_len [2:0]: the number of symbols in the current letter.
  - letter_len increments on each sym_valid, saturating at 7.
  - It is valid with letter_end, then clears on the next rise or on IDLE entry.
  - press_err clears it.
  - Reset value is 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package morse_pkg:
  - State enum: IDLE, PRESS, GAP, LGAP, ABORT.
  - Default tick constants: DASH, LETTER_GAP, WORD_GAP, MAX_PRESS.
  - Symbol encoding: DOT=0, DASH=1.
- Sub-module morse_key_sync: 2-flop synchronizer plus registered rise/fall detection, with async active-low reset.

Test Plan:
- Reset, then press for 1 tick and release -> sym_valid=1 with sym_is_dash=0, 3 cycles after key_in falls; busy=1.
- Press for 4 ticks -> sym_is_dash=1. Then hold released for 3 ticks -> letter_end exactly at the 3rd tick. At the 7th tick -> word_end, busy=0.
- Dot, a gap of 2 ticks, then a dash -> two sym_valid pulses and no letter_end between them. With MORSE_LETTER_LEN_EN, letter_len=2 at letter_end.
- Hold for 12 ticks -> press_err at the 12th tick and no sym_valid on release. The block returns to IDLE after release.
- Key rise in the same cycle as tick_100ms while in GAP with cnt=2 -> no letter_end; state is PRESS with cnt=0.
- Drop enable mid-press, or assert rst mid-press -> no pulses, busy=0 on the next cycle (rst: immediately).
